// File: rtl/eprisc_board_uart.sv
// eprisc_board_uart: FSB-mapped 8N1 UART with a TX FIFO and an RX holding register.
// Define EPRISC_UART_RXFIFO_EN to replace the RX holding register with a FIFO of depth pTxDepth.
module eprisc_board_uart #(
   parameter int pTxDepth      = 4,
   parameter int pResetDivisor = 434
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [31:0] iAddress,
   inout  wire  [31:0] bData,
   input  logic        iWrite,
   input  logic        iEnable,
   input  logic        iReceive,
   output logic        oTransmit,
   output logic        oInterrupt
);
   localparam int kPtrW = $clog2(pTxDepth);
   localparam int kCntW = kPtrW + 1;
   localparam logic [kCntW-1:0] kDepth = kCntW'(pTxDepth);

   typedef enum logic [1:0] {sIdle, sStart, sData, sStop} tUartState;

   logic [1:0]  regSel;
   logic        txPush, statusWr, divisorWr, rxPopReq;
   logic [15:0] divisor;
   logic        txOvr, rxOvr, frameErr;
   logic [31:0] readData;

   assign regSel    = iAddress[1:0];
   assign txPush    = iEnable & iWrite & (regSel == 2'd0);
   assign statusWr  = iEnable & iWrite & (regSel == 2'd2);
   assign divisorWr = iEnable & iWrite & (regSel == 2'd3);
   assign rxPopReq  = iEnable & ~iWrite & (regSel == 2'd1);

   // TX FIFO
   logic [7:0]       txMem [pTxDepth];
   logic [kPtrW-1:0] txWrPtr, txRdPtr;
   logic [kCntW-1:0] txCount;
   logic             txPop, txFull, txEmpty, txAccept;

   assign txFull   = (txCount == kDepth);
   assign txEmpty  = (txCount == '0);
   assign txAccept = txPush & (~txFull | txPop);

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         txWrPtr <= '0;
         txRdPtr <= '0;
         txCount <= '0;
      end else begin
         if (txAccept) txWrPtr <= txWrPtr + 1'b1;
         if (txPop)    txRdPtr <= txRdPtr + 1'b1;
         case ({txAccept, txPop})
            2'b10:   txCount <= txCount + 1'b1;
            2'b01:   txCount <= txCount - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge iClock) begin
      if (txAccept) txMem[txWrPtr] <= bData[7:0];
   end

   // TX shifter: the divisor is latched when a byte is popped, so a frame never changes rate
   tUartState   txState, txNext;
   logic [15:0] txCnt, txDiv;
   logic [2:0]  txBit;
   logic [7:0]  txShift;
   logic        txTick, txBusy;

   assign txTick = (txCnt == txDiv);
   assign txBusy = (txState != sIdle);

   always_comb begin
      txNext = txState;
      txPop  = 1'b0;
      case (txState)
         sIdle:  if (!txEmpty) begin txNext = sStart; txPop = 1'b1; end
         sStart: if (txTick) txNext = sData;
         sData:  if (txTick && txBit == 3'd7) txNext = sStop;
         sStop:  if (txTick) begin
                    if (!txEmpty) begin txNext = sStart; txPop = 1'b1; end
                    else txNext = sIdle;
                 end
         default: txNext = sIdle;
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         txState <= sIdle;
         txCnt   <= '0;
         txBit   <= '0;
         txDiv   <= 16'(pResetDivisor);
      end else begin
         txState <= txNext;
         if (txPop) begin
            txCnt <= '0;
            txBit <= '0;
            txDiv <= divisor;
         end else if (txState != sIdle) begin
            if (txTick) begin
               txCnt <= '0;
               if (txState == sData) txBit <= txBit + 1'b1;
            end else begin
               txCnt <= txCnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (txPop) txShift <= txMem[txRdPtr];
      else if (txState == sData && txTick) txShift <= txShift >> 1;
   end

   always_comb begin
      case (txState)
         sStart:  oTransmit = 1'b0;
         sData:   oTransmit = txShift[0];
         default: oTransmit = 1'b1;
      endcase
   end

   // RX synchroniser; rxPrev gives the falling-edge detect for the start bit
   logic rxMeta, rxSync, rxPrev;

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
         rxPrev <= 1'b1;
      end else begin
         rxMeta <= iReceive;
         rxSync <= rxMeta;
         rxPrev <= rxSync;
      end
   end

   tUartState   rxState, rxNext;
   logic [15:0] rxCnt, rxDiv, rxHalf;
   logic [16:0] rxDivP1;
   logic [2:0]  rxBit;
   logic [7:0]  rxShift;
   logic        rxSample, rxStoreReq, frameErrSet;

   assign rxDivP1 = {1'b0, rxDiv} + 17'd1;
   assign rxHalf  = rxDivP1[16:1];
   // rxCnt starts at 1 on entering START, so the start sample lands (DIVISOR+1)/2 clocks after the edge
   assign rxSample = (rxState == sStart) ? (rxCnt >= rxHalf) :
                     (rxState == sData || rxState == sStop) ? (rxCnt == rxDiv) : 1'b0;
   assign frameErrSet = (rxState == sStop) & rxSample & ~rxSync;

   always_comb begin
      rxNext = rxState;
      case (rxState)
         sIdle:  if (rxPrev && !rxSync) rxNext = sStart;
         sStart: if (rxSample) rxNext = rxSync ? sIdle : sData;
         sData:  if (rxSample && rxBit == 3'd7) rxNext = sStop;
         sStop:  if (rxSample) rxNext = sIdle;
         default: rxNext = sIdle;
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rxState    <= sIdle;
         rxCnt      <= '0;
         rxBit      <= '0;
         rxDiv      <= 16'(pResetDivisor);
         rxStoreReq <= 1'b0;
      end else begin
         rxState    <= rxNext;
         rxStoreReq <= (rxState == sStop) & rxSample & rxSync;
         if (rxState == sIdle) begin
            rxCnt <= 16'd1;
            rxBit <= '0;
            rxDiv <= divisor;
         end else if (rxSample) begin
            rxCnt <= '0;
            if (rxState == sData) rxBit <= rxBit + 1'b1;
         end else begin
            rxCnt <= rxCnt + 1'b1;
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (rxState == sData && rxSample) rxShift <= {rxSync, rxShift[7:1]};
   end

   // RX storage; a store that meets a pop of the last byte is not an overrun
   logic       rxValid, rxFull, rxPop, rxPush, rxOvrSet;
   logic [7:0] rxHead;

   assign rxPop    = rxPopReq & rxValid;
   assign rxPush   = rxStoreReq & (~rxFull | rxPop);
   assign rxOvrSet = rxStoreReq & rxFull & ~rxPop;

`ifdef EPRISC_UART_RXFIFO_EN
   logic [7:0]       rxMem [pTxDepth];
   logic [kPtrW-1:0] rxWrPtr, rxRdPtr;
   logic [kCntW-1:0] rxCount;
   logic [7:0]       rxLast;

   assign rxValid = (rxCount != '0);
   assign rxFull  = (rxCount == kDepth);
   assign rxHead  = rxValid ? rxMem[rxRdPtr] : rxLast;

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rxWrPtr <= '0;
         rxRdPtr <= '0;
         rxCount <= '0;
      end else begin
         if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
         if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
         case ({rxPush, rxPop})
            2'b10:   rxCount <= rxCount + 1'b1;
            2'b01:   rxCount <= rxCount - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge iClock) begin
      if (rxPush) rxMem[rxWrPtr] <= rxShift;
      if (rxPop)  rxLast <= rxMem[rxRdPtr];
   end
`else
   logic [7:0] rxHold;
   logic       rxHoldValid;

   assign rxValid = rxHoldValid;
   assign rxFull  = rxHoldValid;
   assign rxHead  = rxHold;

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset)      rxHoldValid <= 1'b0;
      else if (rxPush) rxHoldValid <= 1'b1;
      else if (rxPop)  rxHoldValid <= 1'b0;
   end

   always_ff @(posedge iClock) begin
      if (rxPush) rxHold <= rxShift;
   end
`endif

   // Control registers and sticky flags; a new event wins over a same-cycle clear
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         divisor  <= 16'(pResetDivisor);
         txOvr    <= 1'b0;
         rxOvr    <= 1'b0;
         frameErr <= 1'b0;
      end else begin
         if (divisorWr) divisor <= bData[15:0];
         if (statusWr && bData[3]) rxOvr    <= 1'b0;
         if (statusWr && bData[5]) frameErr <= 1'b0;
         if (statusWr && bData[6]) txOvr    <= 1'b0;
         if (txPush && !txAccept)  txOvr    <= 1'b1;
         if (rxOvrSet)             rxOvr    <= 1'b1;
         if (frameErrSet)          frameErr <= 1'b1;
      end
   end

   always_comb begin
      readData = '0;
      case (regSel)
         2'd1:    readData[8:0]  = {rxValid, rxHead};
         2'd2:    readData[6:0]  = {txOvr, frameErr, txBusy, rxOvr, rxValid, txEmpty, txFull};
         2'd3:    readData[15:0] = divisor;
         default: ;
      endcase
   end

   assign bData      = (iEnable & ~iWrite & ~iReset) ? readData : 32'hz;
   assign oInterrupt = rxValid | frameErr | rxOvr;

   logic unusedBits;
   assign unusedBits = ^{iAddress[31:2], bData[31:16], rxDivP1[0]};

endmodule
